// File: rtl/p_div_if.sv
// Request/response bundle for the packed divider; master drives operands, slave returns result.
// Defining P_DIV_SIGNED_EN adds the sgn operand-type bit.
interface p_div_if;
  logic        valid;
  logic        ready;
  logic        div;
  logic [4:0]  pw;
  logic [31:0] crs1;
  logic [31:0] crs2;
  logic [31:0] result;
`ifdef P_DIV_SIGNED_EN
  logic        sgn;

  modport master (output valid, div, pw, crs1, crs2, sgn, input ready, result);
  modport slave  (input valid, div, pw, crs1, crs2, sgn, output ready, result);
`else
  modport master (output valid, div, pw, crs1, crs2, input ready, result);
  modport slave  (input valid, div, pw, crs1, crs2, output ready, result);
`endif
endinterface

// File: rtl/p_div.sv
// Iterative packed restoring divider: lanes of 32/16/8/4/2 bits, one quotient bit per lane per cycle.
// Optional P_DIV_SIGNED_EN adds sgn: two's-complement lanes via magnitude divide plus combinational sign fix-up.
module p_div (
  input logic     clock,
  input logic     resetn,
  p_div_if.slave  io
);

  logic [5:0]       count_q, count_d;
  logic [31:0]      qr_q, qr_d;
  logic [31:0]      rr_q, rr_d;
  logic [5:0]       lane_w;
  logic             done;
  logic             first;
  logic [31:0]      qr_src, rr_src, d_src;
  logic [4:0][31:0] step_q, step_r;

`ifdef P_DIV_SIGNED_EN
  logic [31:0] lane_lsb, lane_msb;
  logic [31:0] dmag_q, dmag_d;
  logic [31:0] s1_m, s2_m, dnz_m, mag1, mag2;

  // Per-lane two's-complement negate where en is set; carry restarts at each lane LSB.
  function automatic logic [31:0] lane_neg(input logic [31:0] x, input logic [31:0] en,
                                           input logic [31:0] lsb);
    logic        c;
    logic [31:0] y;
    c = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (lsb[i]) c = 1'b1;
      y[i] = en[i] ? (~x[i] ^ c) : x[i];
      c    = c & ~x[i];
    end
    return y;
  endfunction

  function automatic logic [31:0] lane_bcast(input logic [31:0] x, input logic [31:0] msb);
    logic        cur;
    logic [31:0] y;
    cur = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (msb[i]) cur = x[i];
      y[i] = cur;
    end
    return y;
  endfunction

  function automatic logic [31:0] lane_nz(input logic [31:0] x, input logic [31:0] lsb,
                                          input logic [31:0] msb);
    logic        acc;
    logic [31:0] y;
    acc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (lsb[i]) acc = 1'b0;
      acc  = acc | x[i];
      y[i] = acc;
    end
    return lane_bcast(y, msb);
  endfunction
`endif

  always_comb begin
    lane_w = 6'd32;
`ifdef P_DIV_SIGNED_EN
    lane_lsb = 32'h0000_0001;
    lane_msb = 32'h8000_0000;
`endif
    case (io.pw)
      5'b00010: begin
        lane_w = 6'd16;
`ifdef P_DIV_SIGNED_EN
        lane_lsb = 32'h0001_0001;
        lane_msb = 32'h8000_8000;
`endif
      end
      5'b00100: begin
        lane_w = 6'd8;
`ifdef P_DIV_SIGNED_EN
        lane_lsb = 32'h0101_0101;
        lane_msb = 32'h8080_8080;
`endif
      end
      5'b01000: begin
        lane_w = 6'd4;
`ifdef P_DIV_SIGNED_EN
        lane_lsb = 32'h1111_1111;
        lane_msb = 32'h8888_8888;
`endif
      end
      5'b10000: begin
        lane_w = 6'd2;
`ifdef P_DIV_SIGNED_EN
        lane_lsb = 32'h5555_5555;
        lane_msb = 32'hAAAA_AAAA;
`endif
      end
      default: ;
    endcase
  end

  // >= rather than == so an illegal or changed pw always terminates instead of running away.
  assign done  = (count_q >= lane_w);
  assign first = (count_q == 6'd0);

`ifdef P_DIV_SIGNED_EN
  always_comb begin
    s1_m   = io.sgn ? lane_bcast(io.crs1, lane_msb) : 32'h0;
    s2_m   = io.sgn ? lane_bcast(io.crs2, lane_msb) : 32'h0;
    dnz_m  = lane_nz(io.crs2, lane_lsb, lane_msb);
    mag1   = lane_neg(io.crs1, s1_m, lane_lsb);
    mag2   = lane_neg(io.crs2, s2_m, lane_lsb);
    qr_src = first ? mag1 : qr_q;
    d_src  = first ? mag2 : dmag_q;
    rr_src = first ? 32'h0 : rr_q;
  end
`else
  always_comb begin
    qr_src = first ? io.crs1 : qr_q;
    d_src  = io.crs2;
    rr_src = first ? 32'h0 : rr_q;
  end
`endif

  // One restoring step for every lane width in parallel; pw picks which one is kept.
  for (genvar k = 0; k < 5; k++) begin : g_w
    localparam int W = 32 >> k;
    for (genvar l = 0; l < 32 / W; l++) begin : g_l
      localparam int B = l * W;
      logic [W:0]   r_ext;
      logic [W-1:0] d_lane, r_sub;
      logic         ge;
      assign d_lane = d_src[B+W-1:B];
      assign r_ext  = {rr_src[B+W-1:B], qr_src[B+W-1]};
      assign ge     = (r_ext >= {1'b0, d_lane});
      assign r_sub  = r_ext[W-1:0] - d_lane;
      assign step_r[k][B+W-1:B] = ge ? r_sub : r_ext[W-1:0];
      assign step_q[k][B+W-1:B] = {qr_src[B+W-2:B], ge};
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_q <= 6'd0;
      qr_q    <= 32'h0;
      rr_q    <= 32'h0;
`ifdef P_DIV_SIGNED_EN
      dmag_q  <= 32'h0;
`endif
    end else begin
      count_q <= count_d;
      qr_q    <= qr_d;
      rr_q    <= rr_d;
`ifdef P_DIV_SIGNED_EN
      dmag_q  <= dmag_d;
`endif
    end
  end

  // Abort (valid low) and finish both clear the state; otherwise take one step.
  always_comb begin
    count_d = 6'd0;
    qr_d    = 32'h0;
    rr_d    = 32'h0;
`ifdef P_DIV_SIGNED_EN
    dmag_d  = 32'h0;
`endif
    if (io.valid && !done) begin
      count_d = count_q + 6'd1;
`ifdef P_DIV_SIGNED_EN
      dmag_d  = d_src;
`endif
      case (io.pw)
        5'b00010: begin qr_d = step_q[1]; rr_d = step_r[1]; end
        5'b00100: begin qr_d = step_q[2]; rr_d = step_r[2]; end
        5'b01000: begin qr_d = step_q[3]; rr_d = step_r[3]; end
        5'b10000: begin qr_d = step_q[4]; rr_d = step_r[4]; end
        default:  begin qr_d = step_q[0]; rr_d = step_r[0]; end
      endcase
    end
  end

  always_comb begin
    io.ready = io.valid && done;
`ifdef P_DIV_SIGNED_EN
    // Quotient negates on sign mismatch unless the divisor is zero; remainder follows the dividend.
    io.result = io.div ? lane_neg(qr_q, (s1_m ^ s2_m) & dnz_m, lane_lsb)
                       : lane_neg(rr_q, s1_m, lane_lsb);
`else
    io.result = io.div ? qr_q : rr_q;
`endif
  end

endmodule
